// File: rtl/hilo_pkg.sv
// hilo_pkg -- shared definitions for the HI/LO multiply/divide unit.
//   XLEN_DEF   : default operand and HI/LO width
//   ITER_COUNT : number of ITER cycles for an iterative operation
//   CNT_W      : width of the iteration counter
//   hilo_op_e  : operation encoding carried on the 3-bit op port
//   hilo_state_e : control FSM states (also exported on the debug port)
package hilo_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } hilo_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ITER  = 2'd1,
        ST_FIXUP = 2'd2
    } hilo_state_e;

endpackage

// File: rtl/hilo_div_step.sv
// hilo_div_step -- one combinational restoring-division step.
//   rem_shifted : previous partial remainder shifted left with the next
//                 dividend bit appended (XLEN+1 bits, cannot overflow since
//                 the previous remainder is always below the divisor)
//   divisor     : divisor magnitude
//   rem_next    : partial remainder after the trial subtraction
//   q_bit       : quotient bit produced by this step
module hilo_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_shifted,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);

    logic [XLEN:0] diff;

    always_comb begin
        diff  = rem_shifted - {1'b0, divisor};
        q_bit = (rem_shifted >= {1'b0, divisor});
        // Restore (keep the shifted remainder) when the subtraction would go negative.
        rem_next = q_bit ? diff[XLEN-1:0] : rem_shifted[XLEN-1:0];
    end

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv -- HI/LO multiply/divide unit.
//   CLK, RESET      : clock, synchronous active-high reset
//   op_valid, op    : request strobe and operation (hilo_op_e encoding)
//   A, B            : rs / rt operands, latched at acceptance
//   busy            : high while an operation is in progress
//   done            : one-cycle pulse when a mult/div writes HI/LO
//   HI_OUT, LO_OUT  : architectural HI/LO registers
//   dbg_state       : current control FSM state
// Build option MULDIV_ITER_MULT_EN: when defined, MULT/MULTU run as a 32-step
// shift-add through ITER/FIXUP; otherwise they use a single-cycle multiplier.
//
// Handshake: a request is taken on a rising CLK edge where op_valid=1 and
// busy=0; any request presented while busy=1 is dropped, not queued.
module hilo_muldiv
    import hilo_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [XLEN-1:0]   A,
    input  logic [XLEN-1:0]   B,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   HI_OUT,
    output logic [XLEN-1:0]   LO_OUT,
    output hilo_state_e       dbg_state
);

    hilo_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    hilo_op_e         op_q;
    logic [XLEN-1:0]  hi_q, lo_q;
    logic [XLEN-1:0]  acc_hi_q;   // remainder (div) / product upper half (iterative mult)
    logic [XLEN-1:0]  acc_lo_q;   // dividend->quotient (div) / multiplier->product lower half
    logic [XLEN-1:0]  opnd_q;     // divisor or multiplicand
    logic             neg_q_q;    // result (quotient / product) must be negated
    logic             neg_r_q;    // remainder must be negated
    logic             div0_q;     // divide by zero: finish without writing HI/LO
    logic             done_q;

    logic             accept;
    logic             in_mult, in_div, in_signed, a_neg, b_neg;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic             op_is_div_q;
    logic [XLEN-1:0]  step_rem;
    logic             step_q;
    logic [XLEN-1:0]  quot_fix, rem_fix;
    logic [2*XLEN-1:0] mul_res;

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign HI_OUT    = hi_q;
    assign LO_OUT    = lo_q;
    assign dbg_state = state_q;
    assign accept    = op_valid && !busy;

    // Request decode on the live inputs (used only at acceptance).
    always_comb begin
        in_mult   = (op == OP_MULT) || (op == OP_MULTU);
        in_div    = (op == OP_DIV)  || (op == OP_DIVU);
        in_signed = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = in_signed && A[XLEN-1];
        b_neg     = in_signed && B[XLEN-1];
        a_mag     = a_neg ? (~A + 1'b1) : A;
        b_mag     = b_neg ? (~B + 1'b1) : B;
    end

    assign op_is_div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);

    hilo_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_shifted (({acc_hi_q, acc_lo_q[XLEN-1]})),
        .divisor     (opnd_q),
        .rem_next    (step_rem),
        .q_bit       (step_q)
    );

    // Sign fix-up of the magnitude divide result.
    always_comb begin
        quot_fix = neg_q_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
        rem_fix  = neg_r_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
    end

`ifdef MULDIV_ITER_MULT_EN
    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole product right by one.
    logic [XLEN:0] mul_sum;
    always_comb begin
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_res = neg_q_q ? (~{acc_hi_q, acc_lo_q} + 1'b1) : {acc_hi_q, acc_lo_q};
    end
`else
    // Single-cycle multiplier on the raw latched operands.
    logic [2*XLEN-1:0] prod_s, prod_u;
    always_comb begin
        prod_s  = {{XLEN{acc_lo_q[XLEN-1]}}, acc_lo_q} * {{XLEN{opnd_q[XLEN-1]}}, opnd_q};
        prod_u  = {{XLEN{1'b0}}, acc_lo_q} * {{XLEN{1'b0}}, opnd_q};
        mul_res = (op_q == OP_MULT) ? prod_s : prod_u;
    end
`endif

    // Control FSM: state register.
    always_ff @(posedge CLK) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Control FSM: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && in_div) begin
                    state_d = (B == '0) ? ST_FIXUP : ST_ITER;
                end else if (accept && in_mult) begin
`ifdef MULDIV_ITER_MULT_EN
                    state_d = ST_ITER;
`else
                    state_d = ST_FIXUP;
`endif
                end
            end
            // The counter reaches 0 on the edge that leaves ITER.
            ST_ITER:  if (cnt_q == CNT_W'(1)) state_d = ST_FIXUP;
            ST_FIXUP: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath and architectural registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            op_q     <= OP_MULT;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (op == OP_MTHI) hi_q <= A;
                        if (op == OP_MTLO) lo_q <= A;
                        if (in_mult || in_div) begin
                            op_q     <= hilo_op_e'(op);
                            cnt_q    <= CNT_W'(ITER_COUNT);
                            acc_hi_q <= '0;
                            neg_q_q  <= a_neg ^ b_neg;
                            neg_r_q  <= a_neg;
                            div0_q   <= in_div && (B == '0);
`ifdef MULDIV_ITER_MULT_EN
                            acc_lo_q <= a_mag;
                            opnd_q   <= b_mag;
`else
                            acc_lo_q <= in_mult ? A : a_mag;
                            opnd_q   <= in_mult ? B : b_mag;
`endif
                        end
                    end
                end
                ST_ITER: begin
                    cnt_q <= cnt_q - 1'b1;
`ifdef MULDIV_ITER_MULT_EN
                    if (op_is_div_q) begin
                        acc_hi_q <= step_rem;
                        acc_lo_q <= {acc_lo_q[XLEN-2:0], step_q};
                    end else begin
                        acc_hi_q <= mul_sum[XLEN:1];
                        acc_lo_q <= {mul_sum[0], acc_lo_q[XLEN-1:1]};
                    end
`else
                    acc_hi_q <= step_rem;
                    acc_lo_q <= {acc_lo_q[XLEN-2:0], step_q};
`endif
                end
                ST_FIXUP: begin
                    done_q <= 1'b1;
                    if (op_is_div_q) begin
                        if (!div0_q) begin
                            lo_q <= quot_fix;
                            hi_q <= rem_fix;
                        end
                    end else begin
                        hi_q <= mul_res[2*XLEN-1:XLEN];
                        lo_q <= mul_res[XLEN-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand and HI/LO width.
REQ-002 SHALL have port CLK  input  1  clock; all state changes occur on its rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port op_valid  input  1  request strobe.
REQ-005 SHALL have port op  input  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-006 SHALL have port A  input  XLEN  rs operand (dividend or multiplicand).
REQ-007 SHALL have port B  input  XLEN  rt operand (divisor or multiplier).
REQ-008 SHALL have port busy  output  1  an operation is in progress; the pipeline stalls the issuing stage.
REQ-009 SHALL have port done  output  1  one-cycle pulse when HI/LO are written by a mult or div operation.
REQ-010 SHALL have ports HI_OUT and LO_OUT  output  XLEN each  architectural HI/LO, fed to the ALU HI_IN/LO_IN for mfhi/mflo.

Function
REQ-011 SHALL accept a request on a rising edge where op_valid=1 and busy=0; requests arriving while busy=1 are ignored.
REQ-012 SHALL, for MTHI/MTLO, write A into HI/LO at the acceptance edge, keep busy=0, and keep done=0.
REQ-013 SHALL implement the FSM states IDLE, ITER, FIXUP.
- IDLE->ITER on an accepted mult/div.
- ITER->FIXUP after 32 iterations.
- FIXUP->IDLE after one cycle.
REQ-014 SHALL keep an iteration counter of 6 bits, loaded with 32 on acceptance and decremented once per ITER cycle; the FSM leaves ITER when the counter reaches 0.
REQ-015 SHALL, for DIV/DIVU, perform a restoring divide on operand magnitudes (signed for DIV, raw for DIVU), one quotient bit per ITER cycle.
REQ-016 SHALL, in FIXUP, apply the sign rules:
- the quotient is negated when the signs of A and B differ (DIV only);
- the remainder takes the sign of A.
REQ-017 SHALL write the quotient into LO and the remainder into HI.
REQ-018 SHALL produce busy=1 for exactly 33 cycles after acceptance of an iterative op, with HI/LO written and done=1 on the 33rd edge after acceptance.
REQ-019 SHALL produce truncation-toward-zero results for DIV; 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
REQ-020 SHALL, on divide by zero (B=0), leave HI/LO unchanged, skip ITER, and pulse done one cycle after acceptance with busy=1 for that one cycle.
REQ-021 SHALL, for MULT/MULTU, produce the full 2*XLEN signed or unsigned product, with HI = upper half and LO = lower half.
REQ-022 SHALL latch A, B and op at acceptance; input changes during busy have no effect.
REQ-023 SHALL hold HI_OUT/LO_OUT stable at their previous values during ITER/FIXUP (no partial results visible).

Reset
REQ-024 SHALL, while RESET=1 at a rising edge, force HI=0, LO=0, busy=0, done=0, state=IDLE and counter=0, aborting any in-flight op without writing results.
REQ-025 SHALL give RESET priority over a simultaneous op_valid.

Configuration
REQ-026 SHALL, when MULDIV_ITER_MULT_EN is defined, compute MULT/MULTU by 32-step shift-add through ITER/FIXUP with the same 33-cycle timing as divide.
REQ-027 SHALL, when MULDIV_ITER_MULT_EN is undefined, compute MULT/MULTU with a single-cycle multiplier: busy=1 for one cycle and HI/LO written with done=1 one edge after acceptance.
REQ-028 SHALL keep divide timing identical in both configurations.

Structure
REQ-029 SHALL take the op encoding enum, the FSM state enum, the XLEN default and the iteration count (32) from shared package hilo_pkg.
REQ-030 SHALL instantiate one combinational sub-module, hilo_div_step, performing one restoring-division step (partial remainder, divisor -> next remainder, quotient bit).

Verification
REQ-031 SHALL cover DIVU 100 / 7: HI=2, LO=14, busy high for 33 cycles, done single pulse.
REQ-032 SHALL cover DIV 0xFFFFFFF9 (-7) / 2: LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); and 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-033 SHALL cover MULT 0xFFFFFFFF * 2: HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU of the same operands: HI=1, LO=0xFFFFFFFE; checked in both configurations including cycle counts.
REQ-034 SHALL cover the sequence MTHI 0x12345678, then DIVU with B=0: HI stays 0x12345678, done pulses after 1 cycle.
REQ-035 SHALL cover RESET asserted at iteration 10 of a DIV: HI=LO=0, busy=0 next cycle, no done pulse; a new op is accepted immediately after.
REQ-036 SHALL cover op_valid held high with new operands during busy: the second request is ignored and the results match the first request only.
